spi_burst_fsm: RTL

SPI_BURST_FSM -- requirements
Module: spi_burst_fsm

---
 rtl/spi_burst_fsm.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_burst_fsm.sv
// SPI slave burst controller: sequences header, read/write data words and handshake pulses.
// Optional multi-word burst support is enabled by defining SPI_BURST_EN.
module spi_burst_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sClkPosEdge,
  input  logic readWriteEnable,
  input  logic chipSelectConditioned,
  output logic addressWriteEnable,
  output logic addressIncrement,
  output logic SRWriteEnable,
  output logic misoBufferEnable,
  output logic DMWriteEnable,
  output logic overrun
);

  localparam int CNT_MAX = ((ADDR_BITS + 1) > DATA_BITS) ? (ADDR_BITS + 1) : DATA_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  localparam logic [2:0] HEADER       = 3'd0;
  localparam logic [2:0] DECODE       = 3'd1;
  localparam logic [2:0] READ_LOAD    = 3'd2;
  localparam logic [2:0] READ_SHIFT   = 3'd3;
  localparam logic [2:0] WRITE_SHIFT  = 3'd4;
  localparam logic [2:0] WRITE_COMMIT = 3'd5;
  localparam logic [2:0] INCR         = 3'd6;
  localparam logic [2:0] DONE         = 3'd7;

`ifdef SPI_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_inc;
  logic             lost_edge;
  logic             dir;

  // After a finished data word: continue via INCR in burst builds, otherwise close the frame.
  logic [2:0] word_end_state;
  assign word_end_state = BURST ? INCR : DONE;

  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    lost_edge  = 1'b0;
    if (chipSelectConditioned) begin
      state_next = HEADER;
    end else begin
      case (state)
        HEADER: begin
          if (sClkPosEdge) begin
            if (bit_cnt == HDR_LAST) state_next = DECODE;
            else                     cnt_inc    = 1'b1;
          end
        end
        DECODE: begin
          state_next = readWriteEnable ? READ_LOAD : WRITE_SHIFT;
          lost_edge  = sClkPosEdge;
        end
        READ_LOAD: begin
          state_next = READ_SHIFT;
          lost_edge  = sClkPosEdge;
        end
        READ_SHIFT: begin
          if (sClkPosEdge) begin
            if (bit_cnt == DATA_LAST) state_next = word_end_state;
            else                      cnt_inc    = 1'b1;
          end
        end
        WRITE_SHIFT: begin
          if (sClkPosEdge) begin
            if (bit_cnt == DATA_LAST) state_next = WRITE_COMMIT;
            else                      cnt_inc    = 1'b1;
          end
        end
        WRITE_COMMIT: begin
          state_next = word_end_state;
          lost_edge  = sClkPosEdge;
        end
        INCR: begin
          state_next = dir ? READ_LOAD : WRITE_SHIFT;
          lost_edge  = sClkPosEdge;
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = HEADER;
        end
      endcase
    end
  end

  // Counter restarts on any state change and on deselect, so every phase counts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HEADER;
      bit_cnt <= '0;
      dir     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (chipSelectConditioned || (state_next != state)) begin
        bit_cnt <= '0;
      end else if (cnt_inc) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == DECODE && !chipSelectConditioned) begin
        dir <= readWriteEnable;
      end
      if (lost_edge) begin
        overrun <= 1'b1;
      end
    end
  end

  assign addressWriteEnable = (state == DECODE);
  assign SRWriteEnable      = (state == READ_LOAD);
  assign misoBufferEnable   = (state == READ_SHIFT);
  assign DMWriteEnable      = (state == WRITE_COMMIT);
`ifdef SPI_BURST_EN
  assign addressIncrement   = (state == INCR);
`else
  assign addressIncrement   = 1'b0;
`endif

endmodule
